// File: rtl/counter_sequencer_pkg.sv
// Shared types and reset-default configuration for the counter sequencer.
package counter_sequencer_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic        DEF_DOWN    = 1'b0;
   localparam logic        DEF_ONESHOT = 1'b0;
   localparam int unsigned DEF_DIV     = 0;

   // All-ones terminal value for a counter of the given width.
   function automatic logic [31:0] def_limit(input int unsigned width);
      return (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
   endfunction

endpackage

// File: rtl/counter_sequencer_prescaler.sv
// Prescaler: emits a tick every div+1 enabled clocks; clear restarts, hold freezes.
module seq_prescaler #(
   parameter int DIV_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             hold,
   input  logic [DIV_W-1:0] div,
   output logic             tick
);

   logic [DIV_W-1:0] cnt;

   assign tick = (cnt == div);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (!hold) begin
         cnt <= tick ? '0 : cnt + DIV_W'(1);
      end
   end

endmodule

// File: rtl/counter_sequencer.sv
// Sequencer for a prescaled up/down counter with terminal-count pulse and
// one-shot or auto-reload operation; host config is accepted only in IDLE/DONE.
module counter_sequencer
   import counter_sequencer_pkg::*;
#(
   parameter int WIDTH = 3,
   parameter int DIV_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [WIDTH-1:0] cfg_limit,
   input  logic             cfg_down,
   input  logic             cfg_oneshot,
   input  logic [DIV_W-1:0] cfg_div,
   input  logic             start,
   input  logic             stop,
   output logic [WIDTH-1:0] count,
   output logic             running,
   output logic             tc_pulse,
   output logic             done
);

   localparam logic [WIDTH-1:0] RST_LIMIT = WIDTH'(def_limit(WIDTH));

   state_t           state;
   logic [WIDTH-1:0] limit_reg;
   logic             down_reg;
   logic             oneshot_reg;
   logic [DIV_W-1:0] div_reg;

   logic             cfg_fire;
   logic             launch;
   logic             tick;
   logic             step_en;
   logic             launch_down;
   logic [WIDTH-1:0] launch_limit;
   logic [WIDTH-1:0] launch_val;
   logic [WIDTH-1:0] reload_val;
   logic [WIDTH-1:0] term_val;

   assign cfg_ready = (state == IDLE) || (state == DONE);
   assign cfg_fire  = cfg_valid && cfg_ready;
   assign launch    = cfg_ready && start && !stop;
   assign step_en   = (state == RUN) && !stop && tick;

   // A config word arriving on the launch edge is already the one that launches.
   assign launch_down  = cfg_fire ? cfg_down  : down_reg;
   assign launch_limit = cfg_fire ? cfg_limit : limit_reg;
   assign launch_val   = launch_down ? launch_limit : '0;

   assign reload_val = down_reg ? limit_reg : '0;
   assign term_val   = down_reg ? '0 : limit_reg;

   seq_prescaler #(.DIV_W(DIV_W)) u_prescaler (
      .clk   (clk),
      .rst   (rst),
      .clear (launch),
      .hold  ((state != RUN) || stop),
      .div   (div_reg),
      .tick  (tick)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         limit_reg   <= RST_LIMIT;
         down_reg    <= DEF_DOWN;
         oneshot_reg <= DEF_ONESHOT;
         div_reg     <= DIV_W'(DEF_DIV);
      end else if (cfg_fire) begin
         limit_reg   <= cfg_limit;
         down_reg    <= cfg_down;
         oneshot_reg <= cfg_oneshot;
         div_reg     <= cfg_div;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         count    <= '0;
         running  <= 1'b0;
         tc_pulse <= 1'b0;
         done     <= 1'b0;
      end else begin
         tc_pulse <= 1'b0;
         unique case (state)
            IDLE, DONE: begin
               if (stop) begin
                  state <= IDLE;
                  count <= '0;
                  done  <= 1'b0;
               end else if (start) begin
                  state   <= RUN;
                  count   <= launch_val;
                  running <= 1'b1;
                  done    <= 1'b0;
               end
            end
            RUN: begin
               if (stop) begin
                  state   <= PAUSE;
                  running <= 1'b0;
               end else if (step_en) begin
                  if (count == term_val) begin
                     tc_pulse <= 1'b1;
                     if (oneshot_reg) begin
                        state   <= DONE;
                        running <= 1'b0;
                        done    <= 1'b1;
                     end else begin
                        count <= reload_val;
                     end
                  end else begin
                     count <= down_reg ? count - WIDTH'(1) : count + WIDTH'(1);
                  end
               end
            end
            PAUSE: begin
               if (stop) begin
                  state <= IDLE;
                  count <= '0;
               end else if (start) begin
                  state   <= RUN;
                  running <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer: hand-computed expectations per clock edge.
module tb_counter_sequencer;

   logic       clk;
   logic       rst;
   logic       cfg_valid;
   logic       cfg_ready;
   logic [2:0] cfg_limit;
   logic       cfg_down;
   logic       cfg_oneshot;
   logic [3:0] cfg_div;
   logic       start;
   logic       stop;
   logic [2:0] count;
   logic       running;
   logic       tc_pulse;
   logic       done;

   int n_tests;
   int n_fail;

   counter_sequencer #(.WIDTH(3), .DIV_W(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .cfg_valid   (cfg_valid),
      .cfg_ready   (cfg_ready),
      .cfg_limit   (cfg_limit),
      .cfg_down    (cfg_down),
      .cfg_oneshot (cfg_oneshot),
      .cfg_div     (cfg_div),
      .start       (start),
      .stop        (stop),
      .count       (count),
      .running     (running),
      .tc_pulse    (tc_pulse),
      .done        (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic configure(input logic [2:0] lim, input logic dn, input logic os, input logic [3:0] dv);
      cfg_valid = 1'b1; cfg_limit = lim; cfg_down = dn; cfg_oneshot = os; cfg_div = dv;
      step();
      cfg_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1; step(); start = 1'b0;
   endtask

   task automatic pulse_stop();
      stop = 1'b1; step(); stop = 1'b0;
   endtask

   initial begin
      n_tests = 0; n_fail = 0;
      rst = 1'b0; cfg_valid = 1'b0; cfg_limit = '0; cfg_down = 1'b0;
      cfg_oneshot = 1'b0; cfg_div = '0; start = 1'b0; stop = 1'b0;

      // Reset state
      #12;
      check("rst_count", count, 0);
      check("rst_running", running, 0);
      check("rst_done", done, 0);
      check("rst_tc", tc_pulse, 0);
      check("rst_cfg_ready", cfg_ready, 1);
      rst = 1'b1;
      step();

      // Default config: free-running 0..7 with tc every 8 clocks
      pulse_start();
      check("t1_e0_count", count, 0);
      check("t1_e0_running", running, 1);
      check("t1_e0_cfg_ready", cfg_ready, 0);
      for (int k = 1; k <= 7; k++) begin
         step();
         check("t1_count", count, k);
         check("t1_tc_low", tc_pulse, 0);
      end
      step();
      check("t1_e8_tc", tc_pulse, 1);
      check("t1_e8_count", count, 0);
      step();
      check("t1_e9_tc", tc_pulse, 0);
      check("t1_e9_count", count, 1);
      for (int k = 0; k < 7; k++) step();
      check("t1_e16_tc", tc_pulse, 1);
      check("t1_e16_count", count, 0);
      check("t1_e16_cfg_ready", cfg_ready, 0);
      pulse_stop();
      pulse_stop();
      check("t1_idle_count", count, 0);
      check("t1_idle_cfg_ready", cfg_ready, 1);

      // One-shot down from 5, step every 3 clocks
      configure(3'd5, 1'b1, 1'b1, 4'd2);
      pulse_start();
      check("t2_start_count", count, 5);
      for (int v = 4; v >= 0; v--) begin
         step(); step(); step();
         check("t2_count", count, v);
      end
      step(); step();
      check("t2_pre_tc", tc_pulse, 0);
      check("t2_pre_done", done, 0);
      step();
      check("t2_tc", tc_pulse, 1);
      check("t2_done", done, 1);
      check("t2_count_hold", count, 0);
      check("t2_cfg_ready", cfg_ready, 1);
      check("t2_running", running, 0);
      step();
      check("t2_tc_one_cycle", tc_pulse, 0);
      check("t2_done_stays", done, 1);
      pulse_stop();
      check("t2_stop_done", done, 0);
      check("t2_stop_count", count, 0);

      // Pause / resume, up with div=1
      configure(3'd7, 1'b0, 1'b0, 4'd1);
      pulse_start();
      for (int k = 0; k < 8; k++) step();
      check("t3_count4", count, 4);
      pulse_stop();
      check("t3_pause_running", running, 0);
      for (int k = 0; k < 10; k++) step();
      check("t3_pause_hold", count, 4);
      check("t3_pause_cfg_ready", cfg_ready, 0);
      pulse_start();
      check("t3_resume_running", running, 1);
      check("t3_resume_count", count, 4);
      step();
      check("t3_resume_mid", count, 4);
      step();
      check("t3_resume_step", count, 5);
      step();
      // The next edge would tick; stop on it must discard the tick.
      pulse_stop();
      check("t3_tick_discard", count, 5);
      pulse_stop();
      check("t3_idle_count", count, 0);
      check("t3_idle_running", running, 0);

      // start & stop together: IDLE no-op, PAUSE -> IDLE
      start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
      check("t4_idle_both_running", running, 0);
      check("t4_idle_both_ready", cfg_ready, 1);
      pulse_start();
      pulse_stop();
      start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
      check("t4_pause_both_running", running, 0);
      check("t4_pause_both_ready", cfg_ready, 1);
      check("t4_pause_both_count", count, 0);

      // Config in RUN ignored: limit 3 period stays 4
      configure(3'd3, 1'b0, 1'b0, 4'd0);
      pulse_start();
      cfg_valid = 1'b1; cfg_limit = 3'd2; cfg_div = 4'd0;
      check("t4_run_cfg_ready", cfg_ready, 0);
      step(); step();
      cfg_valid = 1'b0;
      step();
      check("t4_run_count3", count, 3);
      check("t4_run_no_tc", tc_pulse, 0);
      step();
      check("t4_run_tc", tc_pulse, 1);
      check("t4_run_reload", count, 0);
      pulse_stop();
      pulse_stop();

      // Config on the launch edge is used immediately
      cfg_valid = 1'b1; cfg_limit = 3'd4; cfg_down = 1'b1; cfg_oneshot = 1'b0; cfg_div = 4'd0;
      start = 1'b1;
      step();
      cfg_valid = 1'b0; start = 1'b0;
      check("t4_same_edge_cfg", count, 4);
      step();
      check("t4_same_edge_down", count, 3);
      pulse_stop();
      pulse_stop();

      // limit=0: tc every cycle, then async reset mid-run
      configure(3'd0, 1'b0, 1'b0, 4'd0);
      pulse_start();
      check("t5_e0_count", count, 0);
      check("t5_e0_tc", tc_pulse, 0);
      step();
      check("t5_e1_tc", tc_pulse, 1);
      check("t5_e1_count", count, 0);
      step();
      check("t5_e2_tc", tc_pulse, 1);
      #2 rst = 1'b0;
      #1;
      check("t5_async_tc", tc_pulse, 0);
      check("t5_async_running", running, 0);
      check("t5_async_count", count, 0);
      check("t5_async_ready", cfg_ready, 1);
      #2 rst = 1'b1;
      step();
      pulse_start();
      for (int k = 0; k < 7; k++) step();
      check("t5_default_limit", count, 7);
      check("t5_default_no_tc", tc_pulse, 0);
      step();
      check("t5_default_tc", tc_pulse, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
- Controller that sequences a configurable up/down counter datapath: loads it, runs it, pauses it, resumes it and stops it.
- Provides a prescaled step enable, a terminal-count pulse, and one-shot or auto-reload operation.
- Sits between a host-side config/command interface and the counter value consumed by downstream logic (LED/segment drivers, timers).
- With reset-default configuration it behaves as a free-running 0..2^WIDTH-1 wrap-around counter.

Parameters:
- WIDTH, 3, counter width in bits.
- DIV_W, 4, prescaler divide-field width; step every cfg_div+1 clocks.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- cfg_valid  input  1  config word present.
- cfg_ready  output  1  config accepted this cycle when cfg_valid is also 1.
- cfg_limit  input  WIDTH  terminal value (up) / start value (down).
- cfg_down  input  1  1 = count down, 0 = count up.
- cfg_oneshot  input  1  1 = stop at terminal, 0 = auto-reload.
- cfg_div  input  DIV_W  prescale: one step per cfg_div+1 clocks.
- start  input  1  command: run / resume.
- stop  input  1  command: pause / abort.
- count  output  WIDTH  current counter value (registered).
- running  output  1  high in RUN.
- tc_pulse  output  1  one-cycle terminal-count pulse (registered).
- done  output  1  high in DONE.

Behaviour:
- Interface: one clock domain. Reset is asynchronous and active-low on rst; clock is clk.
- Reset values:
  - State IDLE.
  - count=0, tc_pulse=0, running=0, done=0.
  - Prescaler=0.
  - Stored config: limit = all ones, down=0, oneshot=0, div=0.
- States:
  - IDLE, RUN, PAUSE, DONE.
  - cfg_ready = 1 in IDLE and DONE only, and 0 in RUN and PAUSE.
  - cfg_valid while cfg_ready=0 is ignored, not queued.
- Config capture: on a clock edge with cfg_valid & cfg_ready, all four config fields are registered. The new config takes effect on the next start.
- Start value: SV = 0 if up, limit if down. Terminal value: TV = limit if up, 0 if down.
- IDLE/DONE + start (stop=0) -> RUN:
  - Same edge: count<=SV, prescaler<=0, done deasserts.
  - Config captured on that same edge is used (config write has priority in the same cycle).
- RUN:
  - A tick occurs on each edge where prescaler==div. The prescaler then resets to 0; otherwise it increments.
  - On a tick with count != TV: count steps +1 (up) or -1 (down).
  - On a tick with count == TV: tc_pulse<=1 for exactly one cycle, then:
    - auto-reload: count<=SV and the state stays RUN.
    - oneshot: count holds and the state goes to DONE.
  - Period is (limit+1)*(div+1) clocks. limit=0 gives tc on every tick with count constant 0.
- RUN + stop -> PAUSE: count and prescaler freeze. A tick coincident with stop is discarded.
- PAUSE + start -> RUN, resuming from the frozen count and prescaler. No reload.
- PAUSE + stop -> IDLE, count<=0.
- DONE + stop -> IDLE, count<=0.
- Simultaneous start & stop in any state: stop wins. In IDLE this is a no-op.
- start while in RUN: ignored. stop in IDLE: ignored.
- Reset mid-operation: immediate return to reset values, including config. No tc_pulse is generated.
- Arithmetic is modulo 2^WIDTH. Wrap occurs only via terminal reload, never via overflow, since TV bounds the count.

Decomposition:
- Package counter_sequencer_pkg holds:
  - the state enum (IDLE, RUN, PAUSE, DONE);
  - the reset-default config constants (DEF_DOWN=0, DEF_ONESHOT=0, DEF_DIV=0; DEF_LIMIT = all ones, derived from WIDTH).
- One sub-module, seq_prescaler:
  - DIV_W counter with clear, hold and div inputs; tick output.
  - Reused by other timer blocks.
- FSM, config registers and count datapath stay in the top.

Test Plan:
- Reset defaults, start pulse at edge E0, no stop -> count 0,1..7 on E0..E7; E8 tc_pulse=1 (1 cycle), count=0; repeats every 8 clocks; cfg_ready=0 throughout.
- Config limit=5, down=1, oneshot=1, div=2; then start -> count 5 at start edge, decrements every 3 clocks to 0; 3 clocks later tc_pulse=1, done=1, count holds 0, cfg_ready=1.
- Up, limit=7, count=4 in RUN; stop -> count holds 4 for 10 clocks, running=0; start -> resumes, 5 after div+1 clocks; stop, stop -> IDLE, count=0.
- start & stop asserted together in IDLE and in PAUSE -> stays IDLE / goes to IDLE; cfg_valid in RUN with limit=2 -> ignored, period unchanged.
- limit=0, up, auto-reload, div=0 -> count stays 0, tc_pulse high every cycle after the first tick; rst low mid-run -> all outputs 0 asynchronously, limit back to 7.
